lsu_mem_issuer: RTL and testbench

- LSU-side initiator for the data-cache request handshake; the dcache is the receiver.
- Accepts one memory uop at a time from the LSU issue queue and generates the request: address, byte strobe, read mask, lane-replicated store data.
- Drives the request to the dcache and consumes its M1 response.
- Replays loads that miss, and writes results or misalignment exceptions back to the commit side.

---
 rtl/lsu_mem_issuer_if.sv | 54 +++++
 rtl/lsu_mem_issuer.sv | 212 +++++++++++++++++++++
 tb/tb_lsu_mem_issuer.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_issuer_if.sv
// Request/response bus between the LSU issuer (master)
// and the data cache (slave).
interface lsu_mem_issuer_if #(
  parameter int WID_W = 6
);
  logic             req_valid_o;
  logic             req_ready_i;
  logic [31:0]      req_vaddr_o;
  logic [31:0]      req_wdata_o;
  logic [3:0]       req_strb_o;
  logic [3:0]       req_rmask_o;
  logic [1:0]       req_msized_o;
  logic             req_msigned_o;
  logic [WID_W-1:0] req_wid_o;
  logic             resp_valid_i;
  logic             resp_hit_i;
  logic             resp_uncached_i;
  logic [WID_W-1:0] resp_wid_i;
  logic [31:0]      resp_rdata_i;

  modport master (
    output req_valid_o,
    output req_vaddr_o,
    output req_wdata_o,
    output req_strb_o,
    output req_rmask_o,
    output req_msized_o,
    output req_msigned_o,
    output req_wid_o,
    input  req_ready_i,
    input  resp_valid_i,
    input  resp_hit_i,
    input  resp_uncached_i,
    input  resp_wid_i,
    input  resp_rdata_i
  );

  modport slave (
    input  req_valid_o,
    input  req_vaddr_o,
    input  req_wdata_o,
    input  req_strb_o,
    input  req_rmask_o,
    input  req_msized_o,
    input  req_msigned_o,
    input  req_wid_o,
    output req_ready_i,
    output resp_valid_i,
    output resp_hit_i,
    output resp_uncached_i,
    output resp_wid_i,
    output resp_rdata_i
  );
endinterface

// File: rtl/lsu_mem_issuer.sv
// LSU memory issuer: builds one dcache request per uop,
// replays load misses and writes back results or ALE.
module lsu_mem_issuer #(
  parameter int WID_W      = 6,
  parameter int REPLAY_GAP = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             uop_valid_i,
  output logic             uop_ready_o,
  input  logic [31:0]      uop_base_i,
  input  logic [31:0]      uop_imm_i,
  input  logic [31:0]      uop_wdata_i,
  input  logic             uop_store_i,
  input  logic [1:0]       uop_msized_i,
  input  logic             uop_msigned_i,
  input  logic [WID_W-1:0] uop_wid_i,
  lsu_mem_issuer_if.master dc,
  output logic             wb_valid_o,
  output logic [WID_W-1:0] wb_wid_o,
  output logic [31:0]      wb_data_o,
  output logic             wb_uncached_o,
  output logic             wb_ale_o,
  output logic [31:0]      wb_badv_o,
  output logic [CNT_W-1:0] replay_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    GAP
  } state_t;

  typedef struct packed {
    logic [31:0]      vaddr;
    logic [31:0]      wdata;
    logic [3:0]       strb;
    logic [3:0]       rmask;
    logic [1:0]       msized;
    logic             msigned;
    logic [WID_W-1:0] wid;
    logic             store;
  } req_t;

  localparam logic [3:0] GAP_INIT =
    4'(REPLAY_GAP > 0 ? REPLAY_GAP - 1 : 0);

  state_t      state_q;
  state_t      state_d;
  req_t        req_q;
  logic [3:0]  gap_q;

  logic [31:0] va;
  logic [1:0]  sz;
  logic [3:0]  mask;
  logic [31:0] wrep;
  logic        misal;
  logic        accept;
  logic        resp_match;
  logic        done;
  logic        miss;

  assign va = uop_base_i + uop_imm_i;
  assign sz = (uop_msized_i == 2'd3) ? 2'd2
                                     : uop_msized_i;

  always_comb begin
    mask  = 4'b1111;
    wrep  = uop_wdata_i;
    misal = 1'b0;
    unique case (1'b1)
      (sz == 2'd0): begin
        mask = 4'b0001 << va[1:0];
        wrep = {4{uop_wdata_i[7:0]}};
      end
      (sz == 2'd1): begin
        mask  = 4'b0011 << {va[1], 1'b0};
        wrep  = {2{uop_wdata_i[15:0]}};
        misal = va[0];
      end
      default: begin
        mask  = 4'b1111;
        misal = |va[1:0];
      end
    endcase
  end

  assign accept = uop_valid_i & uop_ready_o;

  // responses seen during a flush are dropped outright
  assign resp_match = (state_q == WAIT)
                    & dc.resp_valid_i
                    & (dc.resp_wid_i == req_q.wid)
                    & ~flush_i;
  assign done = resp_match
              & (req_q.store | dc.resp_hit_i);
  assign miss = resp_match & ~done;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept & ~misal) state_d = SEND;
        end
        SEND: begin
          if (dc.req_ready_i) state_d = WAIT;
        end
        WAIT: begin
          if (done) begin
            state_d = IDLE;
          end else if (miss) begin
            state_d = (REPLAY_GAP == 0) ? SEND : GAP;
          end
        end
        GAP: begin
          if (gap_q == 4'd0) state_d = SEND;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    uop_ready_o    = (state_q == IDLE) & ~flush_i & ~rst_n;
    dc.req_valid_o = (state_q == SEND);
  end

  assign dc.req_vaddr_o   = req_q.vaddr;
  assign dc.req_wdata_o   = req_q.wdata;
  assign dc.req_strb_o    = req_q.strb;
  assign dc.req_rmask_o   = req_q.rmask;
  assign dc.req_msized_o  = req_q.msized;
  assign dc.req_msigned_o = req_q.msigned;
  assign dc.req_wid_o     = req_q.wid;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      req_q <= '0;
      gap_q <= '0;
    end else begin
      if (accept & ~misal) begin
        req_q.vaddr   <= va;
        req_q.wdata   <= wrep;
        req_q.strb    <= uop_store_i ? mask : 4'b0000;
        req_q.rmask   <= uop_store_i ? 4'b0000 : mask;
        req_q.msized  <= sz;
        req_q.msigned <= uop_msigned_i;
        req_q.wid     <= uop_wid_i;
        req_q.store   <= uop_store_i;
      end
      if (miss) begin
        gap_q <= GAP_INIT;
      end else if (state_q == GAP && gap_q != 4'd0) begin
        gap_q <= gap_q - 4'd1;
      end
    end
  end

  // writeback fields are zero whenever no pulse is presented
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wb_valid_o    <= 1'b0;
      wb_wid_o      <= '0;
      wb_data_o     <= '0;
      wb_uncached_o <= 1'b0;
      wb_ale_o      <= 1'b0;
      wb_badv_o     <= '0;
    end else begin
      wb_valid_o    <= 1'b0;
      wb_wid_o      <= '0;
      wb_data_o     <= '0;
      wb_uncached_o <= 1'b0;
      wb_ale_o      <= 1'b0;
      wb_badv_o     <= '0;
      if (accept & misal) begin
        wb_valid_o <= 1'b1;
        wb_wid_o   <= uop_wid_i;
        wb_ale_o   <= 1'b1;
        wb_badv_o  <= va;
      end else if (done) begin
        wb_valid_o    <= 1'b1;
        wb_wid_o      <= req_q.wid;
        wb_data_o     <= req_q.store ? 32'd0
                                     : dc.resp_rdata_i;
        wb_uncached_o <= dc.resp_uncached_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      replay_cnt_o <= '0;
    end else if (miss && (~&replay_cnt_o)) begin
      replay_cnt_o <= replay_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lsu_mem_issuer.sv
// Scoreboard bench for lsu_mem_issuer: directed cases plus
// randomized uops against a byte-lane reference model.
module tb_lsu_mem_issuer;
  localparam int WID_W = 6;
  localparam int GAPC  = 2;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             flush_i = 1'b0;
  logic             uop_valid_i = 1'b0;
  logic             uop_ready_o;
  logic [31:0]      uop_base_i = '0;
  logic [31:0]      uop_imm_i = '0;
  logic [31:0]      uop_wdata_i = '0;
  logic             uop_store_i = 1'b0;
  logic [1:0]       uop_msized_i = '0;
  logic             uop_msigned_i = 1'b0;
  logic [WID_W-1:0] uop_wid_i = '0;
  logic             wb_valid_o;
  logic [WID_W-1:0] wb_wid_o;
  logic [31:0]      wb_data_o;
  logic             wb_uncached_o;
  logic             wb_ale_o;
  logic [31:0]      wb_badv_o;
  logic [CNT_W-1:0] replay_cnt_o;

  lsu_mem_issuer_if #(.WID_W(WID_W)) dc();

  lsu_mem_issuer #(
    .WID_W(WID_W),
    .REPLAY_GAP(GAPC),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush_i(flush_i),
    .uop_valid_i(uop_valid_i),
    .uop_ready_o(uop_ready_o),
    .uop_base_i(uop_base_i),
    .uop_imm_i(uop_imm_i),
    .uop_wdata_i(uop_wdata_i),
    .uop_store_i(uop_store_i),
    .uop_msized_i(uop_msized_i),
    .uop_msigned_i(uop_msigned_i),
    .uop_wid_i(uop_wid_i),
    .dc(dc),
    .wb_valid_o(wb_valid_o),
    .wb_wid_o(wb_wid_o),
    .wb_data_o(wb_data_o),
    .wb_uncached_o(wb_uncached_o),
    .wb_ale_o(wb_ale_o),
    .wb_badv_o(wb_badv_o),
    .replay_cnt_o(replay_cnt_o)
  );

  typedef struct {
    logic [WID_W-1:0] wid;
    logic [31:0]      data;
    logic             unc;
    logic             ale;
    logic [31:0]      badv;
  } wb_t;

  wb_t sb[$];
  int  checks = 0;
  int  failures = 0;
  int  exp_replays = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h",
               nm, act, exp);
    end
  endtask

  // reference: size in bytes, lanes touched, lane-copied data
  function automatic void model(
    input  logic [31:0] base,
    input  logic [31:0] imm,
    input  logic [31:0] wd,
    input  logic [1:0]  msz,
    output logic [31:0] va,
    output logic [3:0]  mask,
    output logic [31:0] wrep,
    output bit          mis,
    output logic [1:0]  sz);
    int nb;
    int m;
    va   = base + imm;
    sz   = (msz == 2'd3) ? 2'd2 : msz;
    nb   = 1 << sz;
    mis  = (va % nb) != 0;
    m    = ((1 << nb) - 1) << (va % 4);
    mask = m[3:0];
    for (int i = 0; i < 4; i++)
      wrep[8*i +: 8] = wd[8*(i % nb) +: 8];
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (wb_valid_o === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wb_unexpected actual=wid%0d required=none",
                   wb_wid_o);
        end else begin
          wb_t e;
          e = sb.pop_front();
          chk("wb_wid", 32'(wb_wid_o), 32'(e.wid));
          chk("wb_data", wb_data_o, e.data);
          chk("wb_uncached", 32'(wb_uncached_o), 32'(e.unc));
          chk("wb_ale", 32'(wb_ale_o), 32'(e.ale));
          chk("wb_badv", wb_badv_o, e.badv);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic present(input logic [31:0] base, imm, wd,
                         input bit st,
                         input logic [1:0] msz,
                         input bit sg,
                         input logic [WID_W-1:0] wid);
    int n;
    uop_valid_i   = 1'b1;
    uop_base_i    = base;
    uop_imm_i     = imm;
    uop_wdata_i   = wd;
    uop_store_i   = st;
    uop_msized_i  = msz;
    uop_msigned_i = sg;
    uop_wid_i     = wid;
    n = 0;
    #1;
    while (uop_ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("uop_ready", 32'(uop_ready_o), 32'd1);
  endtask

  task automatic run_uop(input logic [31:0] base, imm, wd,
                         input bit st,
                         input logic [1:0] msz,
                         input bit sg,
                         input logic [WID_W-1:0] wid,
                         input int misses, stall,
                         input bit badwid,
                         input logic [31:0] rdata,
                         input bit unc,
                         input bit hit_st);
    logic [31:0] va, wrep;
    logic [3:0]  mask;
    logic [1:0]  sz;
    bit          mis;
    wb_t         e;
    model(base, imm, wd, msz, va, mask, wrep, mis, sz);
    present(base, imm, wd, st, msz, sg, wid);
    e.wid  = wid;
    e.data = (st || mis) ? 32'd0 : rdata;
    e.unc  = mis ? 1'b0 : unc;
    e.ale  = mis;
    e.badv = mis ? va : 32'd0;
    sb.push_back(e);
    @(negedge clk);
    uop_valid_i = 1'b0;
    if (mis) begin
      chk("ale_no_req", 32'(dc.req_valid_o), 32'd0);
      chk("ale_wb_timing", 32'(wb_valid_o), 32'd1);
    end else begin
      for (int a = 0; a <= misses; a++) begin
        int n;
        n = 0;
        if (a > 0) begin
          n = 1;
          while (dc.req_valid_o !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
          end
          chk("replay_gap", 32'(n), 32'(GAPC + 1));
        end else begin
          while (dc.req_valid_o !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
          end
          chk("req_valid", 32'(dc.req_valid_o), 32'd1);
        end
        if (dc.req_valid_o !== 1'b1) return;
        chk("req_vaddr", dc.req_vaddr_o, va);
        if (st) chk("req_wdata", dc.req_wdata_o, wrep);
        chk("req_strb", 32'(dc.req_strb_o),
            st ? 32'(mask) : 32'd0);
        chk("req_rmask", 32'(dc.req_rmask_o),
            st ? 32'd0 : 32'(mask));
        chk("req_msized", 32'(dc.req_msized_o), 32'(sz));
        chk("req_msigned", 32'(dc.req_msigned_o), 32'(sg));
        chk("req_wid", 32'(dc.req_wid_o), 32'(wid));
        for (int s = 0; s < stall; s++) begin
          dc.req_ready_i = 1'b0;
          @(negedge clk);
          chk("hold_valid", 32'(dc.req_valid_o), 32'd1);
          chk("hold_vaddr", dc.req_vaddr_o, va);
          chk("hold_mask", 32'(dc.req_strb_o | dc.req_rmask_o),
              32'(mask));
        end
        dc.req_ready_i = 1'b1;
        @(negedge clk);
        dc.req_ready_i = 1'b0;
        chk("req_drop", 32'(dc.req_valid_o), 32'd0);
        if (badwid) begin
          dc.resp_valid_i    = 1'b1;
          dc.resp_wid_i      = wid ^ 6'd1;
          dc.resp_hit_i      = 1'b1;
          dc.resp_rdata_i    = ~rdata;
          dc.resp_uncached_i = ~unc;
          @(negedge clk);
          chk("badwid_ignored", 32'(wb_valid_o), 32'd0);
        end
        dc.resp_valid_i    = 1'b1;
        dc.resp_wid_i      = wid;
        dc.resp_hit_i      = st ? hit_st : (a == misses);
        dc.resp_rdata_i    = rdata;
        dc.resp_uncached_i = unc;
        @(negedge clk);
        dc.resp_valid_i = 1'b0;
        if (a < misses) exp_replays++;
      end
      chk("wb_timing", 32'(wb_valid_o), 32'd1);
    end
    @(negedge clk);
    chk("wb_pulse", 32'(wb_valid_o), 32'd0);
    chk("replay_cnt", 32'(replay_cnt_o), 32'(exp_replays));
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] b, im;
    logic [1:0]  msz;
    bit          st;
    int          n;
    dc.req_ready_i     = 1'b0;
    dc.resp_valid_i    = 1'b0;
    dc.resp_hit_i      = 1'b0;
    dc.resp_uncached_i = 1'b0;
    dc.resp_wid_i      = '0;
    dc.resp_rdata_i    = '0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(uop_ready_o), 32'd0);
    chk("rst_req_valid", 32'(dc.req_valid_o), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_vaddr", dc.req_vaddr_o, 32'd0);
    chk("rst_replay", 32'(replay_cnt_o), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(uop_ready_o), 32'd1);

    run_uop(32'h1000, 32'h4, 32'h0, 1'b0, 2'd2, 1'b0, 6'd7,
            0, 0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    run_uop(32'h2000, 32'h3, 32'hAB, 1'b1, 2'd0, 1'b0, 6'd9,
            0, 3, 1'b0, 32'h0, 1'b1, 1'b0);
    run_uop(32'h3000, 32'h1, 32'h0, 1'b0, 2'd1, 1'b1, 6'd11,
            0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    run_uop(32'h5000, 32'h8, 32'h0, 1'b0, 2'd2, 1'b0, 6'd13,
            2, 0, 1'b0, 32'h12345678, 1'b0, 1'b0);
    run_uop(32'h6000, 32'h2, 32'h0, 1'b0, 2'd1, 1'b1, 6'd20,
            0, 1, 1'b1, 32'hFFFF8001, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      b   = $urandom;
      im  = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        b[1:0]  = 2'b00;
        im[1:0] = 2'b00;
      end
      msz = 2'($urandom_range(0, 3));
      st  = 1'($urandom_range(0, 1));
      run_uop(b, im, $urandom, st, msz,
              1'($urandom_range(0, 1)),
              6'($urandom_range(0, 63)),
              st ? 0 : $urandom_range(0, 2),
              $urandom_range(0, 2),
              1'($urandom_range(0, 1)),
              $urandom,
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    // flush while a matching hit arrives in WAIT
    present(32'h4000, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0, 6'd5);
    @(negedge clk);
    uop_valid_i = 1'b0;
    n = 0;
    while (dc.req_valid_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fl_req_valid", 32'(dc.req_valid_o), 32'd1);
    dc.req_ready_i = 1'b1;
    @(negedge clk);
    dc.req_ready_i     = 1'b0;
    flush_i            = 1'b1;
    dc.resp_valid_i    = 1'b1;
    dc.resp_wid_i      = 6'd5;
    dc.resp_hit_i      = 1'b1;
    dc.resp_rdata_i    = 32'hCAFEF00D;
    dc.resp_uncached_i = 1'b0;
    @(negedge clk);
    flush_i         = 1'b0;
    dc.resp_valid_i = 1'b0;
    #1;
    chk("flush_no_wb", 32'(wb_valid_o), 32'd0);
    chk("flush_ready", 32'(uop_ready_o), 32'd1);
    chk("flush_no_req", 32'(dc.req_valid_o), 32'd0);
    @(negedge clk);
    chk("flush_no_wb2", 32'(wb_valid_o), 32'd0);

    // uop offered during flush must be refused
    uop_valid_i  = 1'b1;
    uop_base_i   = 32'h7000;
    uop_imm_i    = 32'h0;
    uop_store_i  = 1'b0;
    uop_msized_i = 2'd2;
    uop_wid_i    = 6'd3;
    flush_i      = 1'b1;
    #1;
    chk("flush_blocks_ready", 32'(uop_ready_o), 32'd0);
    @(negedge clk);
    uop_valid_i = 1'b0;
    flush_i     = 1'b0;
    #1;
    chk("flush_no_accept", 32'(dc.req_valid_o), 32'd0);
    chk("flush_idle", 32'(uop_ready_o), 32'd1);
    chk("flush_keeps_replay", 32'(replay_cnt_o),
        32'(exp_replays));
    @(negedge clk);

    // asynchronous reset while the request is pending
    present(32'h8000, 32'h4, 32'h0, 1'b0, 2'd2, 1'b0, 6'd8);
    @(negedge clk);
    uop_valid_i = 1'b0;
    chk("rs_req_valid", 32'(dc.req_valid_o), 32'd1);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_async_drop", 32'(dc.req_valid_o), 32'd0);
    chk("rst_async_wb", 32'(wb_valid_o), 32'd0);
    chk("rst_async_cnt", 32'(replay_cnt_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    exp_replays = 0;
    @(negedge clk);
    chk("rst_no_wb", 32'(wb_valid_o), 32'd0);
    chk("rst_sb_empty", 32'(sb.size()), 32'd0);
    run_uop(32'h9000, 32'h2, 32'h0, 1'b0, 2'd0, 1'b0, 6'd1,
            1, 0, 1'b0, 32'h000000F0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
